// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int WORD_SIZE = 32;
  localparam logic [WORD_SIZE-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SQUASH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, pipeline control and IF/ID outputs.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic                 stall_in;
  logic                 branch_taken_in;
  logic [WORD_SIZE-1:0] branch_target_in;
  logic                 imem_req;
  logic [WORD_SIZE-1:0] imem_addr;
  logic                 imem_ack;
  logic [WORD_SIZE-1:0] imem_rdata;
  logic [WORD_SIZE-1:0] if_id_instruction;
  logic [WORD_SIZE-1:0] if_id_pc;
  logic                 if_id_valid;

  modport master (
    input  stall_in, branch_taken_in, branch_target_in, imem_ack, imem_rdata,
    output imem_req, imem_addr, if_id_instruction, if_id_pc, if_id_valid
  );

  modport slave (
    output stall_in, branch_taken_in, branch_target_in, imem_ack, imem_rdata,
    input  imem_req, imem_addr, if_id_instruction, if_id_pc, if_id_valid
  );
endinterface

// File: rtl/fetch_unit_if_id_register.sv
// IF/ID pipeline holding register; flush beats load, load beats invalidate.
module if_id_register
  import fetch_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         flush,
  input  logic         invalidate,
  input  logic [W-1:0] d_instr,
  input  logic [W-1:0] d_pc,
  output logic [W-1:0] q_instr,
  output logic [W-1:0] q_pc,
  output logic         q_valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_instr <= W'(NOP);
      q_pc    <= '0;
      q_valid <= 1'b0;
    end else if (flush) begin
      q_instr <= W'(NOP);
      q_pc    <= '0;
      q_valid <= 1'b0;
    end else if (load) begin
      q_instr <= d_instr;
      q_pc    <= d_pc;
      q_valid <= 1'b1;
    end else if (invalidate) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit with stall hold buffer and branch squash.
// Optional FETCH_PERF_CNT_EN adds saturating stall/squash counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          WORD_SIZE = fetch_unit_pkg::WORD_SIZE
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  stall_cycles,
  output logic [31:0]  squash_count
`endif
);
  import fetch_unit_pkg::*;

  fetch_state_t         state;
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] pc_plus4;
  logic [WORD_SIZE-1:0] hold_buf;
  logic [WORD_SIZE-1:0] target_q;
  logic [WORD_SIZE-1:0] target;

  logic                 ld;
  logic                 fl;
  logic                 inv;
  logic [WORD_SIZE-1:0] d_instr;

  assign pc_plus4 = pc + WORD_SIZE'(4);
  assign target   = bus.branch_target_in & ~WORD_SIZE'(3);

  // Address stays on the old pc through SQUASH until the stale response lands.
  assign bus.imem_req  = (state != ST_HOLD);
  assign bus.imem_addr = pc;

  always_comb begin
    ld      = 1'b0;
    fl      = 1'b0;
    inv     = 1'b0;
    d_instr = bus.imem_rdata;
    if (bus.branch_taken_in) begin
      fl = 1'b1;
    end else begin
      case (state)
        ST_FETCH: begin
          if (bus.imem_ack && !bus.stall_in)       ld  = 1'b1;
          else if (!bus.imem_ack && !bus.stall_in) inv = 1'b1;
        end
        ST_HOLD: begin
          if (!bus.stall_in) begin
            ld      = 1'b1;
            d_instr = hold_buf;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_FETCH;
      pc       <= WORD_SIZE'(RESET_PC);
      hold_buf <= '0;
      target_q <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (bus.branch_taken_in) begin
            hold_buf <= '0;
            if (bus.imem_ack) begin
              pc <= target;
            end else begin
              target_q <= target;
              state    <= ST_SQUASH;
            end
          end else if (bus.imem_ack) begin
            if (bus.stall_in) begin
              hold_buf <= bus.imem_rdata;
              state    <= ST_HOLD;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        ST_HOLD: begin
          if (bus.branch_taken_in) begin
            hold_buf <= '0;
            pc       <= target;
            state    <= ST_FETCH;
          end else if (!bus.stall_in) begin
            pc    <= pc_plus4;
            state <= ST_FETCH;
          end
        end
        ST_SQUASH: begin
          // A redirect arriving with the stale ack wins over the latched one.
          if (bus.imem_ack) begin
            pc    <= bus.branch_taken_in ? target : target_q;
            state <= ST_FETCH;
          end else if (bus.branch_taken_in) begin
            target_q <= target;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  if_id_register #(.W(WORD_SIZE)) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load       (ld),
    .flush      (fl),
    .invalidate (inv),
    .d_instr    (d_instr),
    .d_pc       (pc_plus4),
    .q_instr    (bus.if_id_instruction),
    .q_pc       (bus.if_id_pc),
    .q_valid    (bus.if_id_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      squash_count <= '0;
    end else begin
      if (state == ST_FETCH && (bus.stall_in || !bus.imem_ack) && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (bus.branch_taken_in && squash_count != '1)
        squash_count <= squash_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter WORD_SIZE, default 32, width of PC, address and instruction.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 stall_in  input  1  decode-stage hazard stall; hold IF/ID contents.
REQ-006 branch_taken_in  input  1  redirect request from branch resolution.
REQ-007 branch_target_in  input  32  redirect address.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  fetch address, word aligned.
REQ-010 imem_ack  input  1  memory response valid; may assert in the same cycle as imem_req (zero-wait).
REQ-011 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-012 if_id_instruction  output  32  registered instruction to decode.
REQ-013 if_id_pc  output  32  registered PC+4 of that instruction.
REQ-014 if_id_valid  output  1  IF/ID holds a real instruction.

Function
REQ-015 States: FETCH (req outstanding), HOLD (response buffered during stall), SQUASH (discard pending response after redirect).
REQ-016 imem_req=1 in FETCH and SQUASH, 0 in HOLD; imem_addr shall remain stable from assertion until the cycle of imem_ack.
REQ-017 FETCH, ack=1, stall_in=0, no branch: IF/ID <= {imem_rdata, pc+4, valid=1}; pc <= pc+4; stay FETCH; result visible the cycle after ack.
REQ-018 Zero-wait memory (ack every cycle, no stall) shall sustain one instruction per cycle.
REQ-019 FETCH, ack=1, stall_in=1: rdata into hold buffer, IF/ID unchanged, pc unchanged, go HOLD.
REQ-020 FETCH, ack=0: IF/ID unchanged if stall_in=1; otherwise if_id_valid <= 0 (bubble).
REQ-021 HOLD, stall_in=0: IF/ID <= {buffer, pc+4, 1}; pc <= pc+4; go FETCH.
REQ-022 branch_taken_in has priority over stall and ack: IF/ID flushed to {32'h0 NOP, 0, valid=0}; buffer discarded.
REQ-023 Branch with ack=1 same cycle, or in HOLD: data discarded, pc <= target, go FETCH.
REQ-024 Branch in FETCH with ack=0: target latched, go SQUASH; next ack discarded, pc <= latched target, go FETCH.
REQ-025 Branch in SQUASH: latched target overwritten by the newer target.
REQ-026 branch_target_in[1:0] shall be forced to 2'b00.
REQ-027 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).

Reset
REQ-028 On rst=0: pc=RESET_PC, state=FETCH, if_id_instruction=0, if_id_pc=0, if_id_valid=0, buffer=0, latched target=0.
REQ-029 Reset mid-transaction: any later imem_ack for the aborted request shall not be presented by the memory; fetch restarts at RESET_PC the first cycle after release.

Configuration
REQ-030 Macro FETCH_PERF_CNT_EN defined: outputs stall_cycles[31:0] (cycles with stall_in=1 or ack=0 in FETCH) and squash_count[31:0] (branch redirects), both saturating, reset to 0.
REQ-031 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-032 Shared package: state enum, NOP constant 32'h0, WORD_SIZE.
REQ-033 One sub-module if_id_register: IF/ID holding register with load, flush and async active-low reset.

Verification
REQ-034 Zero-wait memory, RESET_PC=0, 4 cycles -> if_id_pc 4, 8, 12, 16, valid=1 each cycle.
REQ-035 Ack with stall_in=1 for 3 cycles, rdata=32'h8C01_0004 -> IF/ID unchanged, imem_req=0 in HOLD; on release IF/ID=8C01_0004, pc advances by 4.
REQ-036 Branch with ack same cycle, target 32'h0000_0103 -> next imem_addr=32'h0000_0100, if_id_valid=0, rdata discarded.
REQ-037 Branch while waiting (ack 2 cycles later), target 32'h40 -> first ack discarded, next imem_addr=32'h40.
REQ-038 pc=32'hFFFF_FFFC, ack -> if_id_pc=0, next imem_addr=0.
REQ-039 rst pulsed low in HOLD -> all outputs at reset values immediately; fetch from RESET_PC after release.
